axi_unpack_addr_p: RTL and testbench



---
 rtl/axi_unpack_addr_p_if.sv | 59 +++++
 rtl/axi_unpack_addr_p.sv | 182 ++++++++++++++++++
 tb/tb_axi_unpack_addr_p.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_unpack_addr_p_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_unpack_addr_p_if
// Description : Bundle for the AXI burst-address unpacker.
//               Burst side : AxADDR, AxLEN, AxSIZE, AxBURST, AxVALID, AxREADY.
//               Beat side  : AddrOut, AddrBeat, AddrLast, AddrValid, AddrReady.
//               The slave modport is the unpacker's view. The master modport
//               is the environment's view: it issues bursts and consumes beats.
// Parameters  : ADDR_WIDTH (>= 12), LEN_WIDTH (4 = AXI3, 8 = AXI4).
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_unpack_addr_p_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    // Burst address channel
    logic [ADDR_WIDTH-1:0] AxADDR;
    logic [LEN_WIDTH-1:0]  AxLEN;
    logic [2:0]            AxSIZE;
    logic [1:0]            AxBURST;
    logic                  AxVALID;
    logic                  AxREADY;

    // Per-beat address stream
    logic [ADDR_WIDTH-1:0] AddrOut;
    logic [LEN_WIDTH-1:0]  AddrBeat;
    logic                  AddrLast;
    logic                  AddrValid;
    logic                  AddrReady;

    modport slave (
        input  AxADDR,
        input  AxLEN,
        input  AxSIZE,
        input  AxBURST,
        input  AxVALID,
        output AxREADY,
        output AddrOut,
        output AddrBeat,
        output AddrLast,
        output AddrValid,
        input  AddrReady
    );

    modport master (
        output AxADDR,
        output AxLEN,
        output AxSIZE,
        output AxBURST,
        output AxVALID,
        input  AxREADY,
        input  AddrOut,
        input  AddrBeat,
        input  AddrLast,
        input  AddrValid,
        output AddrReady
    );
endinterface
`default_nettype wire

// File: rtl/axi_unpack_addr_p.sv
`default_nettype none
// ============================================================================
// Module      : axi_unpack_addr_p
// Description : AXI burst address unpacker. It accepts one burst address and
//               emits one address per data beat on a VALID/READY stream. Each
//               beat carries a beat index and a last-beat flag. FIXED, INCR
//               and WRAP bursts are supported. AxBURST = 2'b11 is handled as
//               INCR.
// Ports       : ACLK        - clock
//               ARESETn     - asynchronous active-low reset
//               bus (slave) - Ax* burst input, Addr* beat output
// Config      : AXI_UADDR_BACK_TO_BACK_EN - when defined, a new burst is
//               accepted in the same cycle the previous burst's last beat is
//               accepted. No idle cycle is inserted between the bursts. This
//               adds a combinational path from AddrReady to AxREADY.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_unpack_addr_p #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input wire                  ACLK,
    input wire                  ARESETn,
    axi_unpack_addr_p_if.slave  bus
);

    localparam logic [1:0]           c_BURST_FIXED = 2'b00;
    localparam logic [1:0]           c_BURST_WRAP  = 2'b10;
    localparam int                   c_PAGE_BITS   = 12;
    localparam logic [LEN_WIDTH-1:0] c_LEN_ONE     = LEN_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [LEN_WIDTH-1:0]  beat_q,  beat_d;
    logic [LEN_WIDTH-1:0]  rem_q,   rem_d;
    logic [LEN_WIDTH-1:0]  len_q,   len_d;
    logic [2:0]            size_q,  size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  last_q,  last_d;
    logic                  valid_q, valid_d;

    logic                  w_ax_ready;
    logic                  w_ax_fire;
    logic                  w_beat_fire;

    logic [LEN_WIDTH-1:0]  w_len_smear;
    logic [ADDR_WIDTH-1:0] w_len_ext;
    logic [ADDR_WIDTH-1:0] w_size_bytes;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_addr_wrap;
    logic [ADDR_WIDTH-1:0] w_addr_incr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [11:0]           w_page_size;
    logic [11:0]           w_page_lo;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
`ifdef AXI_UADDR_BACK_TO_BACK_EN
    // The final beat leaving this cycle frees the engine in time for the next load.
    assign w_ax_ready = ~valid_q | (valid_q & last_q & bus.AddrReady);
`else
    assign w_ax_ready = ~valid_q;
`endif

    assign w_ax_fire   = bus.AxVALID & w_ax_ready;
    assign w_beat_fire = valid_q & bus.AddrReady;

    // ------------------------------------------------------------------------
    // Next-address arithmetic
    // ------------------------------------------------------------------------
    // Fill every bit below the MSB of len with ones. This gives
    // pow2ceil(len+1) - 1, so a wrap length that is not a power of two is
    // rounded up to the next power of two.
    always_comb begin : p_len_smear
        logic [LEN_WIDTH-1:0] v_smear;
        v_smear = len_q;
        for (int i = LEN_WIDTH - 2; i >= 0; i--) begin
            v_smear[i] = v_smear[i+1] | len_q[i];
        end
        w_len_smear = v_smear;
    end

    assign w_len_ext    = ADDR_WIDTH'(w_len_smear);
    assign w_size_bytes = ADDR_WIDTH'(1) << size_q;

    // Wrap window mask, W - 1 = (pow2ceil(len+1) << size) - 1.
    assign w_wrap_mask  = (w_len_ext << size_q) | (w_size_bytes - ADDR_WIDTH'(1));
    assign w_addr_wrap  = (addr_q & ~w_wrap_mask)
                        | ((addr_q + w_size_bytes) & w_wrap_mask);

    // INCR aligns down to the beat size and steps within the 4KB page only.
    assign w_page_size  = 12'd1 << size_q;
    assign w_page_lo    = (addr_q[c_PAGE_BITS-1:0] & ~(w_page_size - 12'd1)) + w_page_size;

    if (ADDR_WIDTH > c_PAGE_BITS) begin : g_page_hold
        assign w_addr_incr = {addr_q[ADDR_WIDTH-1:c_PAGE_BITS], w_page_lo};
    end else begin : g_page_only
        assign w_addr_incr = w_page_lo;
    end

    always_comb begin
        w_addr_next = w_addr_incr;
        case (burst_q)
            c_BURST_FIXED: w_addr_next = addr_q;
            c_BURST_WRAP:  w_addr_next = w_addr_wrap;
            default:       w_addr_next = w_addr_incr;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next state. Loading a new burst takes priority over advancing a beat.
    // This matters only in the back-to-back build, where both handshakes can
    // complete in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        addr_d  = addr_q;
        beat_d  = beat_q;
        rem_d   = rem_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (w_ax_fire) begin
            addr_d  = bus.AxADDR;
            beat_d  = '0;
            rem_d   = bus.AxLEN;
            len_d   = bus.AxLEN;
            size_d  = bus.AxSIZE;
            burst_d = bus.AxBURST;
            last_d  = (bus.AxLEN == '0);
            valid_d = 1'b1;
        end else if (w_beat_fire) begin
            if (last_q) begin
                // The burst is done. The final beat's values stay visible.
                valid_d = 1'b0;
            end else begin
                rem_d  = rem_q - c_LEN_ONE;
                beat_d = beat_q + c_LEN_ONE;
                last_d = (rem_q == c_LEN_ONE);
                addr_d = w_addr_next;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            beat_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.AxREADY   = w_ax_ready;
    assign bus.AddrOut   = addr_q;
    assign bus.AddrBeat  = beat_q;
    assign bus.AddrLast  = last_q;
    assign bus.AddrValid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_unpack_addr_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_unpack_addr_p
// Description : Self-checking bench for axi_unpack_addr_p.
//               A reference model expands each accepted burst into its list
//               of expected beats. The list is derived from the FIXED, INCR
//               and WRAP address rules. A monitor checks the beat stream
//               against this list on every falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_unpack_addr_p;

    localparam int AW = 32;
    localparam int LW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] beat;
        logic          last;
    } beat_t;

    logic  ACLK    = 1'b0;
    logic  ARESETn = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: toggle
    beat_t exp_q[$];

    axi_unpack_addr_p_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    axi_unpack_addr_p #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expand one burst into its beats from the addressing rules.
    function automatic void model_burst(input logic [AW-1:0] a, input int len,
                                        input int size, input logic [1:0] b);
        longint unsigned a0, s, w, wp, off0, lo, ai;
        beat_t bt;
        a0 = a;
        s  = 64'd1 << size;
        for (int i = 0; i <= len; i++) begin
            case (b)
                2'b00: ai = a0;
                2'b10: begin
                    wp = 1;
                    while (wp < longint'(len + 1)) wp = wp * 2;
                    w    = wp * s;
                    off0 = a0 % w;
                    ai   = (a0 - off0) + ((off0 + longint'(i) * s) % w);
                end
                default: begin
                    if (i == 0) ai = a0;
                    else begin
                        lo = (a0 % 4096) - ((a0 % 4096) % s);
                        ai = (a0 - (a0 % 4096)) + ((lo + longint'(i) * s) % 4096);
                    end
                end
            endcase
            bt.addr = AW'(ai);
            bt.beat = LW'(i);
            bt.last = (i == len);
            exp_q.push_back(bt);
        end
    endfunction

    // Monitor: checks handshake policy, valid/queue coherence and beat content.
    initial begin : p_mon
        logic ax_fire;
        forever begin
            @(negedge ACLK);
            if (ARESETn) begin
                ax_fire = bus.AxVALID && bus.AxREADY;
`ifdef AXI_UADDR_BACK_TO_BACK_EN
                check_val("axready", bus.AxREADY,
                          (exp_q.size() == 0) || (exp_q.size() == 1 && bus.AddrReady));
`else
                check_val("axready", bus.AxREADY, exp_q.size() == 0);
`endif
                check_val("addrvalid", bus.AddrValid, exp_q.size() != 0);
                if (bus.AddrValid && exp_q.size() != 0) begin
                    check_val("addrout",  bus.AddrOut,  exp_q[0].addr);
                    check_val("addrbeat", bus.AddrBeat, exp_q[0].beat);
                    check_val("addrlast", bus.AddrLast, exp_q[0].last);
                    if (bus.AddrReady) void'(exp_q.pop_front());
                end
                if (ax_fire)
                    model_burst(bus.AxADDR, int'(bus.AxLEN), int'(bus.AxSIZE), bus.AxBURST);
            end
        end
    end

    // Beat-side ready generator
    initial begin : p_ready
        forever begin
            @(posedge ACLK);
            #1;
            case (ready_mode)
                0:       bus.AddrReady = 1'b1;
                1:       bus.AddrReady = 1'($urandom_range(0, 1));
                default: bus.AddrReady = ~bus.AddrReady;
            endcase
        end
    end

    task automatic send_burst(input logic [AW-1:0] a, input int len, input int size,
                              input logic [1:0] b);
        bit got;
        bus.AxADDR  = a;
        bus.AxLEN   = LW'(len);
        bus.AxSIZE  = 3'(size);
        bus.AxBURST = b;
        bus.AxVALID = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 2000 && !got; n++) begin
            @(negedge ACLK);
            if (bus.AxREADY) got = 1'b1;
        end
        if (!got) check_val("axready_timeout", got, 1);
        @(posedge ACLK);
        #1;
        bus.AxVALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge ACLK);
            n++;
        end
        check_val("drain_done", exp_q.size() == 0, 1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin : p_main
        logic [AW-1:0] ra;
        int rl, rs;
        logic [1:0] rb;
        bus.AxVALID   = 1'b0;
        bus.AxADDR    = '0;
        bus.AxLEN     = '0;
        bus.AxSIZE    = '0;
        bus.AxBURST   = '0;
        bus.AddrReady = 1'b0;

        // Reset values
        repeat (3) @(posedge ACLK);
        #1;
        check_val("rst_addrout",   bus.AddrOut,   0);
        check_val("rst_addrbeat",  bus.AddrBeat,  0);
        check_val("rst_addrlast",  bus.AddrLast,  0);
        check_val("rst_addrvalid", bus.AddrValid, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        check_val("rst_axready", bus.AxREADY, 1);

        // Directed cases
        ready_mode = 0;
        send_burst(32'h0000_1004, 3, 2, 2'b01);   drain();
        send_burst(32'h0000_100C, 3, 2, 2'b10);   drain();
        ready_mode = 2;
        send_burst(32'h0000_0020, 2, 2, 2'b00);   drain();
        ready_mode = 0;
        send_burst(32'h0000_1003, 1, 2, 2'b01);   drain();
        send_burst(32'h0000_1FFC, 1, 2, 2'b01);   drain();
        send_burst(32'h0000_1F80, 255, 0, 2'b01); drain();
        send_burst(32'h0000_1234, 4, 3, 2'b10);   drain();
        send_burst(32'h0000_5000, 2, 1, 2'b11);   drain();

        // Back-to-back: the second burst waits on AxVALID during the first one's last beat
        send_burst(32'h0000_2000, 3, 2, 2'b01);
        send_burst(32'h0000_3000, 1, 2, 2'b01);
        drain();

        // Reset while beat 2 of 4 is presented
        send_burst(32'h0000_4000, 3, 2, 2'b01);
        @(posedge ACLK);
        @(posedge ACLK);
        #2;
        ARESETn = 1'b0;
        #1;
        check_val("midrst_addrout",   bus.AddrOut,   0);
        check_val("midrst_addrbeat",  bus.AddrBeat,  0);
        check_val("midrst_addrlast",  bus.AddrLast,  0);
        check_val("midrst_addrvalid", bus.AddrValid, 0);
        exp_q.delete();
        @(negedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;
        check_val("midrst_axready", bus.AxREADY, 1);
        repeat (8) @(posedge ACLK);
        #1;

        // Randomized bursts with random back-pressure
        ready_mode = 1;
        for (int k = 0; k < 60; k++) begin
            ra = AW'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 15));
            rs = int'($urandom_range(0, 7));
            rb = 2'($urandom_range(0, 3));
            send_burst(ra, rl, rs, rb);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
